// File: rtl/node_port_ctrl_pkg.sv
// Shared definitions for the TIS node port sequencer: target codes, link
// direction indices, FSM encoding and the ANY arbitration orders.
package node_port_ctrl_pkg;

  localparam logic [2:0] TARGET_NIL   = 3'd0;
  localparam logic [2:0] TARGET_ACC   = 3'd1;
  localparam logic [2:0] TARGET_UP    = 3'd2;
  localparam logic [2:0] TARGET_DOWN  = 3'd3;
  localparam logic [2:0] TARGET_LEFT  = 3'd4;
  localparam logic [2:0] TARGET_RIGHT = 3'd5;
  localparam logic [2:0] TARGET_ANY   = 3'd6;
  localparam logic [2:0] TARGET_LAST  = 3'd7;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;

  // Priority lists: the lowest 2-bit slot holds the highest-priority direction.
  localparam logic [7:0] RD_PRIO = {DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT};
  localparam logic [7:0] WR_PRIO = {DIR_DOWN, DIR_RIGHT, DIR_LEFT, DIR_UP};

  // LAST only counts as a port once a direction has been recorded.
  function automatic logic is_port(input logic [2:0] code, input logic lv);
    return (code >= TARGET_UP) && !((code == TARGET_LAST) && !lv);
  endfunction

  function automatic logic [1:0] target_dir(input logic [2:0] code, input logic [1:0] last);
    if (code == TARGET_LAST) return last;
    return 2'(code - TARGET_UP);
  endfunction

endpackage

// File: rtl/node_port_ctrl_if.sv
// Neighbour link bundle: four read channels with per-port data and four
// write channels sharing one data word.
interface node_port_ctrl_if #(parameter int DATA_W = 11);
  logic        [4*DATA_W-1:0] in_data;
  logic        [3:0]          in_valid;
  logic        [3:0]          in_ready;
  logic signed [DATA_W-1:0]   out_data;
  logic        [3:0]          out_valid;
  logic        [3:0]          out_ready;

  modport master (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
  modport slave  (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
endinterface

// File: rtl/node_port_ctrl_prio.sv
// Fixed-priority one-hot arbiter over the four link directions; the order is
// a parameter so reads and writes can use different rankings.
module port_prio_sel #(
  parameter logic [7:0] ORDER = 8'b11_10_01_00
) (
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] idx
);
  always_comb begin
    grant = '0;
    idx   = '0;
    // Walk from lowest to highest priority so the best requester wins last.
    for (int i = 3; i >= 0; i--) begin
      if (req[ORDER[2*i +: 2]]) begin
        grant = 4'b0001 << ORDER[2*i +: 2];
        idx   = ORDER[2*i +: 2];
      end
    end
  end
endmodule

// File: rtl/node_port_ctrl.sv
// Blocking port-transfer sequencer for one TIS node (read, then write).
// Optional stall watchdog with `deadlock` output: define NODE_PORT_DEADLOCK_EN.
module node_port_ctrl
  import node_port_ctrl_pkg::*;
#(
  parameter int DATA_W = 11
`ifdef NODE_PORT_DEADLOCK_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [2:0]               src,
  input  logic [2:0]               dst,
  input  logic signed [DATA_W-1:0] src_val,
  output logic signed [DATA_W-1:0] data,
  output logic                     done,
  output logic                     busy,
  node_port_ctrl_if.master         link,
`ifdef NODE_PORT_DEADLOCK_EN
  output logic                     deadlock,
`endif
  output logic [1:0]               last_dir,
  output logic                     last_vld
);
  state_t     state, state_nxt;
  logic [2:0] src_q, dst_q;
  logic [3:0] rd_grant, wr_grant;
  logic [1:0] rd_idx, wr_idx, rd_dir;
  logic       rd_hs, wr_hs;

  port_prio_sel #(.ORDER(RD_PRIO)) u_rd_prio (.req(link.in_valid),  .grant(rd_grant), .idx(rd_idx));
  port_prio_sel #(.ORDER(WR_PRIO)) u_wr_prio (.req(link.out_ready), .grant(wr_grant), .idx(wr_idx));

  assign rd_dir = (src_q == TARGET_ANY) ? rd_idx : target_dir(src_q, last_dir);

  always_comb begin
    link.in_ready  = '0;
    link.out_valid = '0;
    link.out_data  = '0;
    if (state == ST_RD) begin
      link.in_ready = (src_q == TARGET_ANY) ? rd_grant : (4'b0001 << rd_dir);
    end
    if (state == ST_WR) begin
      link.out_data = data;
      // ANY offers everywhere until someone is ready, then only to the winner.
      if (dst_q == TARGET_ANY) link.out_valid = (|link.out_ready) ? wr_grant : 4'b1111;
      else                     link.out_valid = 4'b0001 << target_dir(dst_q, last_dir);
    end
  end

  assign rd_hs = (state == ST_RD) && |(link.in_valid & link.in_ready);
  assign wr_hs = (state == ST_WR) && |(link.out_valid & link.out_ready);
  assign done  = (state == ST_DONE);
  assign busy  = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) begin
        if (is_port(src, last_vld))      state_nxt = ST_RD;
        else if (is_port(dst, last_vld)) state_nxt = ST_WR;
        else                             state_nxt = ST_DONE;
      end
      ST_RD:   if (rd_hs) state_nxt = is_port(dst_q, last_vld) ? ST_WR : ST_DONE;
      ST_WR:   if (wr_hs) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      src_q    <= TARGET_NIL;
      dst_q    <= TARGET_NIL;
      data     <= '0;
      last_dir <= '0;
      last_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req) begin
        src_q <= src;
        dst_q <= dst;
        if (!is_port(src, last_vld)) data <= src_val;
      end
      if (rd_hs) begin
        data <= $signed(link.in_data[int'(rd_dir)*DATA_W +: DATA_W]);
        if (src_q == TARGET_ANY) begin
          last_dir <= rd_idx;
          last_vld <= 1'b1;
        end
      end
      if (wr_hs && dst_q == TARGET_ANY) begin
        last_dir <= wr_idx;
        last_vld <= 1'b1;
      end
    end
  end

`ifdef NODE_PORT_DEADLOCK_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall_cnt;
  logic          stalled;

  assign stalled = (state == ST_RD) || (state == ST_WR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      deadlock  <= 1'b0;
    end else begin
      if (state == ST_IDLE) stall_cnt <= '0;
      else if (stalled && stall_cnt != CW'(TIMEOUT)) stall_cnt <= stall_cnt + 1'b1;
      if (state_nxt == ST_IDLE) deadlock <= 1'b0;
      else if (stalled && stall_cnt >= CW'(TIMEOUT - 1)) deadlock <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_node_port_ctrl.sv
// Directed bench for node_port_ctrl: a vector table of single transfers plus
// hand-written stall, LAST and mid-transfer reset sequences.
module tb_node_port_ctrl;
  import node_port_ctrl_pkg::*;

  localparam int DATA_W = 11;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req;
  logic [2:0]               src, dst;
  logic signed [DATA_W-1:0] src_val;
  logic signed [DATA_W-1:0] data;
  logic                     done, busy;
  logic [1:0]               last_dir;
  logic                     last_vld;
`ifdef NODE_PORT_DEADLOCK_EN
  logic                     deadlock;
`endif

  node_port_ctrl_if #(.DATA_W(DATA_W)) link ();

  node_port_ctrl #(
    .DATA_W(DATA_W)
`ifdef NODE_PORT_DEADLOCK_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst), .src_val(src_val),
    .data(data), .done(done), .busy(busy), .link(link),
`ifdef NODE_PORT_DEADLOCK_EN
    .deadlock(deadlock),
`endif
    .last_dir(last_dir), .last_vld(last_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]               src, dst;
    logic signed [DATA_W-1:0] sv;
    logic [3:0]               iv;
    logic [4*DATA_W-1:0]      words;
    logic [3:0]               ordy;
    int                       cyc;
    logic signed [DATA_W-1:0] ed;
    logic [3:0]               ir, ov;
    logic [1:0]               ld;
    logic                     lv;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [4*DATA_W-1:0] pack4(input int u, input int d, input int l, input int r);
    return {11'(r), 11'(l), 11'(d), 11'(u)};
  endfunction

  function automatic vec_t mk(input logic [2:0] s, input logic [2:0] d, input int sv,
                              input logic [3:0] iv, input logic [4*DATA_W-1:0] w,
                              input logic [3:0] ordy, input int cyc, input int ed,
                              input logic [3:0] ir, input logic [3:0] ov,
                              input logic [1:0] ld, input logic lv);
    vec_t t;
    t.src = s;   t.dst = d;     t.sv = 11'(sv); t.iv = iv; t.words = w; t.ordy = ordy;
    t.cyc = cyc; t.ed = 11'(ed); t.ir = ir;     t.ov = ov; t.ld = ld;   t.lv = lv;
    return t;
  endfunction

  task automatic run_vec(input vec_t t, input string nm);
    logic [3:0] ir_seen = '0;
    logic [3:0] ov_seen = '0;
    int         od = 0;
    int         got_cyc = -1;
    src = t.src; dst = t.dst; src_val = t.sv;
    link.in_valid = t.iv; link.in_data = t.words; link.out_ready = t.ordy;
    req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      ir_seen |= link.in_ready;
      if (link.out_valid != 4'b0000) begin
        ov_seen |= link.out_valid;
        od = int'(link.out_data);
      end
      if (done) begin
        got_cyc = c;
        break;
      end
    end
    req = 1'b0; link.in_valid = '0; link.out_ready = '0;
    chk({nm, "_done_cycle"}, got_cyc, t.cyc);
    chk({nm, "_data"}, int'(data), int'(t.ed));
    chk({nm, "_in_ready"}, int'(ir_seen), int'(t.ir));
    chk({nm, "_out_valid"}, int'(ov_seen), int'(t.ov));
    if (t.ov != 4'b0000) chk({nm, "_out_data"}, od, int'(t.ed));
    chk({nm, "_last_dir"}, int'(last_dir), int'(t.ld));
    chk({nm, "_last_vld"}, int'(last_vld), int'(t.lv));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_data"}, int'(data), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_in_ready"}, int'(link.in_ready), 0);
    chk({nm, "_out_valid"}, int'(link.out_valid), 0);
    chk({nm, "_out_data"}, int'(link.out_data), 0);
    chk({nm, "_last_dir"}, int'(last_dir), 0);
    chk({nm, "_last_vld"}, int'(last_vld), 0);
  endtask

  vec_t tv[11];

  initial begin
    logic done_seen;
    reset = 1'b1; req = 1'b0; src = TARGET_NIL; dst = TARGET_NIL; src_val = '0;
    link.in_valid = '0; link.in_data = '0; link.out_ready = '0;

    tv[0]  = mk(TARGET_NIL,   TARGET_ACC,   -42,  4'b0000, '0,                4'b0000, 1, -42,   4'b0000, 4'b0000, 2'd0, 1'b0);
    tv[1]  = mk(TARGET_ACC,   TARGET_LAST,  9,    4'b0000, '0,                4'b1111, 1, 9,     4'b0000, 4'b0000, 2'd0, 1'b0);
    tv[2]  = mk(TARGET_LEFT,  TARGET_ACC,   0,    4'b0100, pack4(0,0,123,0),  4'b0000, 2, 123,   4'b0100, 4'b0000, 2'd0, 1'b0);
    tv[3]  = mk(TARGET_ANY,   TARGET_NIL,   0,    4'b1111, pack4(1,2,3,4),    4'b0000, 2, 3,     4'b0100, 4'b0000, 2'd2, 1'b1);
    tv[4]  = mk(TARGET_LAST,  TARGET_NIL,   0,    4'b0100, pack4(0,0,55,0),   4'b0000, 2, 55,    4'b0100, 4'b0000, 2'd2, 1'b1);
    tv[5]  = mk(TARGET_UP,    TARGET_ANY,   0,    4'b0001, pack4(7,0,0,0),    4'b1010, 3, 7,     4'b0001, 4'b1000, 2'd3, 1'b1);
    tv[6]  = mk(TARGET_ACC,   TARGET_RIGHT, -1024,4'b0000, '0,                4'b1000, 2, -1024, 4'b0000, 4'b1000, 2'd3, 1'b1);
    tv[7]  = mk(TARGET_ACC,   TARGET_LAST,  1023, 4'b0000, '0,                4'b1000, 2, 1023,  4'b0000, 4'b1000, 2'd3, 1'b1);
    tv[8]  = mk(TARGET_ANY,   TARGET_NIL,   0,    4'b1010, pack4(0,-5,0,6),   4'b0000, 2, 6,     4'b1000, 4'b0000, 2'd3, 1'b1);
    tv[9]  = mk(TARGET_ACC,   TARGET_ANY,   100,  4'b0000, '0,                4'b0110, 2, 100,   4'b0000, 4'b0100, 2'd2, 1'b1);
    tv[10] = mk(TARGET_NIL,   TARGET_NIL,   0,    4'b0000, '0,                4'b0000, 1, 0,     4'b0000, 4'b0000, 2'd2, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_in");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("rst_out");

    for (int k = 0; k < 11; k++) run_vec(tv[k], $sformatf("v%0d", k));

    // LEFT read whose word only arrives in cycle 5.
    src = TARGET_LEFT; dst = TARGET_ACC; src_val = '0;
    link.in_data = pack4(0, 0, 123, 0); link.in_valid = '0; req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_c%0d_in_ready", c), int'(link.in_ready), 4);
      chk($sformatf("stall_c%0d_busy", c), int'(busy), 1);
      chk($sformatf("stall_c%0d_done", c), int'(done), 0);
      if (c == 5) link.in_valid = 4'b0100;
    end
    @(posedge clk); #1;
    chk("stall_c6_done", int'(done), 1);
    chk("stall_c6_data", int'(data), 123);
    req = 1'b0; link.in_valid = '0;
    @(posedge clk); #1;
    chk("stall_idle_busy", int'(busy), 0);

    // ANY read sets LAST=LEFT, then a LAST read ignores the RIGHT offer.
    run_vec(mk(TARGET_ANY, TARGET_NIL, 0, 4'b1111, pack4(1,2,3,4), 4'b0000, 2, 3, 4'b0100, 4'b0000, 2'd2, 1'b1), "any_again");
    src = TARGET_LAST; dst = TARGET_NIL;
    link.in_data = pack4(0, 0, 77, 88); link.in_valid = 4'b1000; req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("last_c%0d_in_ready", c), int'(link.in_ready), 4);
      chk($sformatf("last_c%0d_done", c), int'(done), 0);
    end
    link.in_valid = 4'b1100;
    @(posedge clk); #1;
    chk("last_done", int'(done), 1);
    chk("last_data", int'(data), 77);
    req = 1'b0; link.in_valid = '0;
    @(posedge clk); #1;

    // DOWN read that never completes, aborted by reset in cycle 6.
    src = TARGET_DOWN; dst = TARGET_ACC; req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c <= 5) chk($sformatf("abort_c%0d_done", c), int'(done), 0);
`ifdef NODE_PORT_DEADLOCK_EN
      if (c == 4) chk("abort_c4_deadlock", int'(deadlock), 0);
      if (c == 5) chk("abort_c5_deadlock", int'(deadlock), 1);
`endif
    end
    reset = 1'b1; req = 1'b0;
    #1;
    chk_reset_outputs("abort_rst");
`ifdef NODE_PORT_DEADLOCK_EN
    chk("abort_rst_deadlock", int'(deadlock), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      done_seen |= done;
    end
    chk("abort_no_done", int'(done_seen), 0);
    chk("abort_idle_busy", int'(busy), 0);

    run_vec(mk(TARGET_ACC, TARGET_NIL, -7, 4'b0000, '0, 4'b0000, 1, -7, 4'b0000, 4'b0000, 2'd0, 1'b0), "recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
